// File: rtl/pattern_bist_ctrl.sv
// pattern_bist_ctrl: LFSR-driven BIST sequencer with MISR response compaction
// and golden-signature compare, one instance per pattern DUT.
module pattern_bist_ctrl #(
  parameter int unsigned N_IN    = 11,
  parameter int unsigned N_OUT   = 9,
  parameter int unsigned LAT     = 3,
  parameter int unsigned NUM_PAT = 256
) (
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       seed,
  input  logic [15:0]       golden,
  input  logic [N_OUT-1:0]  resp,
  output logic [N_IN-1:0]   stim,
  output logic              dut_rst_n,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       signature,
  output logic [15:0]       pat_cnt
);

  localparam int unsigned SIG_W = 16;
  localparam int unsigned PH_W  = 4;
  localparam logic [SIG_W-1:0] SEED_DEFAULT = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [PH_W-1:0]   ph_q;
  logic [SIG_W-1:0]  lfsr_q;
  logic [SIG_W-1:0]  golden_q;
  logic [LAT-1:0]    vpipe_q;

  logic              load_c;
  logic              run_c;
  logic              cap_c;
  logic [LAT-1:0]    vpipe_nxt_c;
  logic [SIG_W-1:0]  lfsr_nxt_c;
  logic [SIG_W-1:0]  misr_nxt_c;
  logic [SIG_W-1:0]  seed_eff_c;

  // Fibonacci LFSR step, taps 16/14/13/11
  function automatic logic [SIG_W-1:0] lfsr_step(input logic [SIG_W-1:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // MISR step: same polynomial, response folded in zero-extended
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] m,
                                                 input logic [N_OUT-1:0] r);
    return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ SIG_W'(r);
  endfunction

  // Valid pipe shift: a 1 enters for each applied pattern
  if (LAT == 1) begin : g_vpipe_1
    assign vpipe_nxt_c = run_c;
  end else begin : g_vpipe_n
    assign vpipe_nxt_c = {vpipe_q[LAT-2:0], run_c};
  end

  assign cap_c      = vpipe_q[LAT-1];
  assign lfsr_nxt_c = lfsr_step(lfsr_q);
  assign misr_nxt_c = cap_c ? misr_step(signature, resp) : signature;
  assign seed_eff_c = (seed == '0) ? SEED_DEFAULT : seed;

  // State register
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control strobes; abort overrides everything
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    run_c   = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_RST;
            load_c  = 1'b1;
          end
        end
        S_RST: begin
          if (ph_q == PH_W'(1)) state_d = S_RUN;
        end
        S_RUN: begin
          run_c = 1'b1;
          if (pat_cnt == SIG_W'(NUM_PAT - 1)) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (ph_q == PH_W'(LAT - 1)) state_d = S_DRAIN == state_q ? S_DONE : state_q;
        end
        S_DONE: begin
          if (start) begin
            state_d = S_RST;
            load_c  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Phase counter timing the RST and DRAIN dwell
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      ph_q <= '0;
    end else if ((state_d != state_q) || !(state_q inside {S_RST, S_DRAIN})) begin
      ph_q <= '0;
    end else begin
      ph_q <= ph_q + PH_W'(1);
    end
  end

  // Status outputs follow the next state so they line up with it
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      dut_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      dut_rst_n <= (state_d != S_RST);
      busy      <= (state_d inside {S_RST, S_RUN, S_DRAIN});
      done      <= (state_d == S_DONE);
    end
  end

  // Stimulus: zero while the DUT is held in reset, held through DRAIN
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      stim <= '0;
    end else if (state_d == S_RST) begin
      stim <= '0;
    end else if (run_c) begin
      stim <= lfsr_q[N_IN-1:0];
    end
  end

  // Run datapath: LFSR, pattern counter, valid pipe, MISR, verdict
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      lfsr_q    <= '0;
      golden_q  <= '0;
      pat_cnt   <= '0;
      signature <= '0;
      vpipe_q   <= '0;
      pass      <= 1'b0;
    end else if (abort) begin
      vpipe_q <= '0;
      pass    <= 1'b0;
    end else if (load_c) begin
      lfsr_q    <= seed_eff_c;
      golden_q  <= golden;
      pat_cnt   <= '0;
      signature <= '0;
      vpipe_q   <= vpipe_nxt_c;
      pass      <= 1'b0;
    end else begin
      vpipe_q   <= vpipe_nxt_c;
      signature <= misr_nxt_c;
      if (run_c) begin
        lfsr_q <= lfsr_nxt_c;
        if (pat_cnt != SIG_W'(NUM_PAT)) pat_cnt <= pat_cnt + SIG_W'(1);
      end
      // Verdict includes the capture landing on the DONE-entry edge
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
        pass <= (misr_nxt_c == golden_q);
      end
    end
  end

endmodule

// File: tb/tb_pattern_bist_ctrl.sv
// Bench for pattern_bist_ctrl: expected stim queued per run, expected
// signature from a reference MISR over the responses the bench drives.
module tb_pattern_bist_ctrl;

  localparam int unsigned N_IN    = 11;
  localparam int unsigned N_OUT   = 9;
  localparam int unsigned LAT     = 3;
  localparam int unsigned NUM_PAT = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [15:0]       seed;
  logic [15:0]       golden;
  logic [N_OUT-1:0]  resp;
  logic [N_IN-1:0]   stim;
  logic              dut_rst_n;
  logic              busy;
  logic              done;
  logic              pass;
  logic [15:0]       signature;
  logic [15:0]       pat_cnt;

  int total = 0;
  int bad   = 0;
  logic [N_IN-1:0] stim_q[$];

  pattern_bist_ctrl #(
    .N_IN(N_IN), .N_OUT(N_OUT), .LAT(LAT), .NUM_PAT(NUM_PAT)
  ) dut (
    .blif_clk_net  (clk),
    .blif_reset_net(rst_n),
    .start         (start),
    .abort         (abort),
    .seed          (seed),
    .golden        (golden),
    .resp          (resp),
    .stim          (stim),
    .dut_rst_n     (dut_rst_n),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .signature     (signature),
    .pat_cnt       (pat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_lfsr(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [15:0] ref_misr(input logic [15:0] m, input logic [N_OUT-1:0] r);
    logic [15:0] rx;
    rx = '0;
    rx[N_OUT-1:0] = r;
    return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ rx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full run; mode 0: resp=0, 1: resp=1 on first capture only, 2: random
  task automatic do_run(input logic [15:0] sd, input logic [15:0] gd,
                        input int mode, input bit poke, input string nm);
    logic [15:0]      l;
    logic [15:0]      m;
    logic [N_OUT-1:0] rq[$];
    logic [N_OUT-1:0] r;
    logic [N_IN-1:0]  es;
    logic [N_IN-1:0]  last;
    logic             exp_pass;
    int               first_e;
    int               last_e;
    stim_q.delete();
    l = (sd == 16'h0000) ? 16'hACE1 : sd;
    for (int i = 0; i < int'(NUM_PAT); i++) begin
      stim_q.push_back(l[N_IN-1:0]);
      l = ref_lfsr(l);
    end
    m = '0;
    for (int i = 0; i < int'(NUM_PAT); i++) begin
      if (mode == 2)                r = N_OUT'($urandom);
      else if (mode == 1 && i == 0) r = N_OUT'(1);
      else                          r = '0;
      rq.push_back(r);
      m = ref_misr(m, r);
    end
    exp_pass = (m == gd);
    last = '0;

    seed = sd; golden = gd; resp = '0; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if ({busy, done, dut_rst_n} !== 3'b100) begin
      bad++; $display("FAIL %s start_edge busy/done/dut_rst_n got=%b exp=100", nm, {busy, done, dut_rst_n});
    end
    total++;
    if (stim !== '0 || pat_cnt !== 16'd0) begin
      bad++; $display("FAIL %s start_edge stim/pat_cnt got=%h/%0d exp=0/0", nm, stim, pat_cnt);
    end
    tick();
    total++;
    if (dut_rst_n !== 1'b0) begin
      bad++; $display("FAIL %s edge1 dut_rst_n got=%b exp=0", nm, dut_rst_n);
    end
    tick();
    total++;
    if (dut_rst_n !== 1'b1 || stim !== '0) begin
      bad++; $display("FAIL %s edge2 dut_rst_n/stim got=%b/%h exp=1/0", nm, dut_rst_n, stim);
    end

    first_e = 3 + int'(LAT);
    last_e  = 2 + int'(LAT) + int'(NUM_PAT);
    for (int e = 3; e <= last_e; e++) begin
      if (e >= first_e) resp = rq.pop_front();
      else if (mode == 2) resp = N_OUT'($urandom);
      else resp = '0;
      start = poke && (e == 4);
      tick();
      start = 1'b0;
      if (e < 3 + int'(NUM_PAT)) begin
        es = stim_q.pop_front();
        last = es;
        total++;
        if (stim !== es || pat_cnt !== 16'(e - 2)) begin
          bad++; $display("FAIL %s run_e%0d stim/pat_cnt got=%h/%0d exp=%h/%0d", nm, e, stim, pat_cnt, es, e - 2);
        end
      end else begin
        total++;
        if (stim !== last) begin
          bad++; $display("FAIL %s drain_e%0d stim_hold got=%h exp=%h", nm, e, stim, last);
        end
      end
      total++;
      if (e < last_e) begin
        if ({busy, done} !== 2'b10) begin
          bad++; $display("FAIL %s e%0d busy/done got=%b exp=10", nm, e, {busy, done});
        end
      end else begin
        if ({busy, done} !== 2'b01) begin
          bad++; $display("FAIL %s done_edge busy/done got=%b exp=01", nm, {busy, done});
        end
      end
    end
    resp = '0;
    total++;
    if (signature !== m) begin
      bad++; $display("FAIL %s signature got=%h exp=%h", nm, signature, m);
    end
    total++;
    if (pass !== exp_pass || pat_cnt !== 16'(NUM_PAT) || dut_rst_n !== 1'b1) begin
      bad++; $display("FAIL %s pass/pat_cnt/dut_rst_n got=%b/%0d/%b exp=%b/%0d/1", nm, pass, pat_cnt, dut_rst_n, exp_pass, NUM_PAT);
    end
    tick();
    tick();
    total++;
    if ({done, pass} !== {1'b1, exp_pass} || signature !== m) begin
      bad++; $display("FAIL %s done_hold done/pass/sig got=%b/%b/%h exp=1/%b/%h", nm, done, pass, signature, exp_pass, m);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed = '0; golden = '0; resp = '0;
    #12;
    total++;
    if ({stim, dut_rst_n, busy, done, pass, signature, pat_cnt} !== '0) begin
      bad++; $display("FAIL reset_values stim=%h dut_rst_n=%b busy=%b done=%b pass=%b sig=%h cnt=%0d exp=all0",
                      stim, dut_rst_n, busy, done, pass, signature, pat_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if ({dut_rst_n, busy, done} !== 3'b100) begin
      bad++; $display("FAIL reset_release dut_rst_n/busy/done got=%b exp=100", {dut_rst_n, busy, done});
    end
  endtask

  task automatic test_basic();
    do_run(16'h0001, 16'h0000, 0, 1'b0, "basic_pass");
  endtask

  task automatic test_golden_mismatch();
    do_run(16'h0001, 16'h0001, 0, 1'b0, "golden_mismatch");
  endtask

  task automatic test_first_capture();
    do_run(16'h0001, 16'h0008, 1, 1'b0, "first_capture");
  endtask

  task automatic test_seed_zero();
    do_run(16'h0000, 16'h0000, 2, 1'b0, "seed_zero");
  endtask

  task automatic test_back_to_back();
    do_run(16'($urandom), 16'($urandom), 2, 1'b1, "b2b_start_ignored");
    do_run(16'($urandom), 16'($urandom), 2, 1'b0, "b2b_rand_a");
    do_run(16'hFFFF, 16'h0000, 2, 1'b0, "b2b_rand_b");
  endtask

  task automatic test_abort();
    seed = 16'h0001; golden = '0; resp = '0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({busy, done, pass, dut_rst_n} !== 4'b0001) begin
      bad++; $display("FAIL abort_status busy/done/pass/dut_rst_n got=%b exp=0001", {busy, done, pass, dut_rst_n});
    end
    total++;
    if (pat_cnt !== 16'd3) begin
      bad++; $display("FAIL abort_pat_cnt_hold got=%0d exp=3", pat_cnt);
    end
    repeat (4) tick();
    total++;
    if (busy !== 1'b0 || pat_cnt !== 16'd3 || signature !== 16'h0000) begin
      bad++; $display("FAIL abort_idle_hold busy/cnt/sig got=%b/%0d/%h exp=0/3/0000", busy, pat_cnt, signature);
    end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    total++;
    if ({busy, dut_rst_n} !== 2'b01) begin
      bad++; $display("FAIL abort_beats_start busy/dut_rst_n got=%b exp=01", {busy, dut_rst_n});
    end
    do_run(16'h0001, 16'h0008, 1, 1'b0, "after_abort");
  endtask

  task automatic test_async_reset();
    seed = 16'h0001; golden = '0; resp = '0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({stim, dut_rst_n, busy, done, pass, signature, pat_cnt} !== '0) begin
      bad++; $display("FAIL async_reset stim=%h dut_rst_n=%b busy=%b done=%b pass=%b sig=%h cnt=%0d exp=all0",
                      stim, dut_rst_n, busy, done, pass, signature, pat_cnt);
    end
    start = 1'b1;
    repeat (3) tick();
    total++;
    if ({busy, dut_rst_n, stim} !== '0) begin
      bad++; $display("FAIL reset_held_start busy/dut_rst_n/stim got=%b/%b/%h exp=0/0/0", busy, dut_rst_n, stim);
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    total++;
    if ({busy, done, dut_rst_n} !== 3'b001 || pat_cnt !== 16'd0) begin
      bad++; $display("FAIL no_resume busy/done/dut_rst_n/cnt got=%b/%0d exp=001/0", {busy, done, dut_rst_n}, pat_cnt);
    end
    do_run(16'h0001, 16'h0000, 0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_golden_mismatch();
    test_first_capture();
    test_seed_zero();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
